memctrl: RTL and testbench
==========================

# memctrl

Byte-serial memory controller between the instruction cache, the data cache and the single-port 8-bit RAM / IO bus. It arbitrates one request at a time, with the data cache having fixed priority. It sequences 1/2/4-byte little-endian reads and writes and returns one `done` pulse per request. Write issue stalls on `io_buffer_full` for IO addresses.

## Interface
Parameters / shared constants (from `config.v`):
- `AddrBus`, 31:0, byte address
- `DataBus`, 31:0, data word
- `LenBus`, 2:0, access length in bytes; legal values 1, 2, 4
- `RamBus`, 7:0, RAM data byte
- `IO_HI`, 2'b11, value of addr[17:16] that marks IO space

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- iDC_en/iDC_ls/iDC_pc/iDC_dt/iDC_len  in  1/1/32/32/3  data-cache request; ls=1 store, ls=0 load
- oDC_done  out  1  one-cycle completion pulse to the data cache
- oDC_dt  out  32  load data, zero-extended, valid while oDC_done=1
- iIC_en/iIC_pc  in  1/32  instruction fetch request, always 4 bytes
- oIC_done  out  1  one-cycle fetch completion pulse
- oIC_inst  out  32  fetched word, valid while oIC_done=1
- mem_din  in  8  RAM read byte
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write
- io_buffer_full  in  1  IO write buffer full

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - If iDC_en=1: latch pc, dt, len, ls and owner=DC. Go to WRITE if ls=1, otherwise READ.
  - Else if iIC_en=1: latch the request with len=4, owner=IC, and go to READ.
  - Requests are sampled only in IDLE.
- **READ** (byte counter c from 0 to n, n=len)
  - For c<n: mem_a=pc+c, mem_wr=0.
  - For c≥1: at the end of the cycle, capture mem_din into byte c-1 of the data register.
  - After c=n, go to DONE.
- **WRITE** (c from 0 to n-1)
  - mem_a=pc+c, mem_dout=dt[8c+7:8c], mem_wr=1.
  - If io_buffer_full=1 and pc[17:16]==IO_HI: hold c, drive mem_wr=0, and do not advance.
  - After c=n-1 is written, go to DONE.
- **DONE**
  - Assert the owner's done output for one cycle, with the data register on oDC_dt or oIC_inst.
  - Drive mem_wr=0.
  - Go to IDLE. The requester drops its enable at this same edge.
- Byte assembly is little-endian. Unused upper bytes are 0; sign extension is the buffer's job.
- The pc+c adder is 32-bit and wraps modulo 2^32.

## Timing
- Reset values:
  - state=IDLE, data register=0
  - oDC_done=0, oIC_done=0, oDC_dt=0, oIC_inst=0
  - mem_wr=0, mem_a=0, mem_dout=0
- Cycle 0 is the first cycle after the accepting edge.
- Load of n bytes: addresses in cycles 0..n-1; oDC_done in cycle n+1.
- Fetch: oIC_done in cycle 5.
- Store of n bytes: writes in cycles 0..n-1; oDC_done in cycle n, plus any IO stall cycles.
- Outside DONE, both done outputs are 0.
- Simultaneous iDC_en and iIC_en in IDLE: DC wins, and IC is served on a later IDLE cycle.
- rdy=0: state, counter and registers hold; mem_wr is forced to 0; done outputs are 0. The pulse resumes when rdy returns.
- rst mid-operation: return to IDLE next cycle; no done pulse; the partial transfer is abandoned.
- Minimum gap between back-to-back requests is one IDLE cycle.

## Structure
- `config.v` holds AddrBus, DataBus, LenBus, RamBus, IO_HI and the 2-bit state encodings.
- Single module; no sub-module. The FSM, counter and byte assembler are small enough to keep flat.

## Test plan
- Reset, then DC load len=4 at 0x100 with RAM[0x100..0x103]=11,22,33,44 -> addresses 0x100..0x103 in cycles 0–3; oDC_done=1 and oDC_dt=0x44332211 in cycle 5.
- DC store len=2, dt=0xAABBCCDD, pc=0x200 -> mem_wr=1 with (0x200,DD) then (0x201,CC); oDC_done in cycle 2; RAM[0x202] unchanged.
- iDC_en and iIC_en raised together in IDLE -> DC served first (oDC_done first); IC fetch starts after the next IDLE cycle; oIC_done 5 cycles after its accept.
- Store len=1 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr=0 for 3 cycles, then one write; oDC_done 4 cycles after accept.
- rdy low for 2 cycles mid-READ of len=4 -> outputs frozen, no byte lost; oDC_dt is correct and done arrives 2 cycles late.
- rst asserted in READ cycle 2 -> no done pulse; state IDLE; a new request afterwards completes normally.

Source files
------------

// File: rtl/memctrl_pkg.sv
// Shared widths, FSM encodings and byte-lane helpers for the byte-serial memory controller.
package memctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 3;
    localparam int RAM_W  = 8;
    localparam int CNT_W  = 3;

    localparam logic [1:0] IO_HI = 2'b11;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [LEN_W-1:0]  len_t;
    typedef logic [RAM_W-1:0]  byte_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } state_t;

    typedef enum logic {
        OWN_DC = 1'b0,
        OWN_IC = 1'b1
    } owner_t;

    function automatic logic is_io(input addr_t addr);
        return (addr[17:16] == IO_HI);
    endfunction

    function automatic byte_t get_byte(input data_t word, input cnt_t idx);
        byte_t b;
        case (idx)
            3'd0:    b = word[7:0];
            3'd1:    b = word[15:8];
            3'd2:    b = word[23:16];
            3'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Lanes beyond the 32-bit word are dropped, so an illegal length cannot corrupt data.
    function automatic data_t put_byte(input data_t word, input cnt_t idx, input byte_t b);
        data_t w;
        w = word;
        case (idx)
            3'd0:    w[7:0]   = b;
            3'd1:    w[15:8]  = b;
            3'd2:    w[23:16] = b;
            3'd3:    w[31:24] = b;
            default: w = word;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/memctrl_if.sv
// Request/response and RAM bus bundle; master = caches and RAM side, slave = the controller.
interface memctrl_if;
    import memctrl_pkg::*;

    logic  iDC_en;
    logic  iDC_ls;
    addr_t iDC_pc;
    data_t iDC_dt;
    len_t  iDC_len;
    logic  oDC_done;
    data_t oDC_dt;

    logic  iIC_en;
    addr_t iIC_pc;
    logic  oIC_done;
    data_t oIC_inst;

    byte_t mem_din;
    byte_t mem_dout;
    addr_t mem_a;
    logic  mem_wr;
    logic  io_buffer_full;

    modport master (
        output iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len,
        output iIC_en, iIC_pc,
        output mem_din, io_buffer_full,
        input  oDC_done, oDC_dt, oIC_done, oIC_inst,
        input  mem_dout, mem_a, mem_wr
    );

    modport slave (
        input  iDC_en, iDC_ls, iDC_pc, iDC_dt, iDC_len,
        input  iIC_en, iIC_pc,
        input  mem_din, io_buffer_full,
        output oDC_done, oDC_dt, oIC_done, oIC_inst,
        output mem_dout, mem_a, mem_wr
    );

endinterface

// File: rtl/memctrl.sv
// Arbitrates data-cache and instruction-cache requests onto a byte-wide RAM bus and
// sequences little-endian 1/2/4-byte transfers with a single done pulse per request.
module memctrl
    import memctrl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    memctrl_if.slave bus
);

    state_t r_state;
    state_t w_state_go;
    state_t w_state_nxt;
    owner_t r_owner;
    addr_t  r_pc;
    data_t  r_dt;
    data_t  r_data;
    len_t   r_len;
    cnt_t   r_cnt;

    logic   w_rd_more;
    logic   w_wr_last;
    logic   w_stall;
    addr_t  w_addr;
    addr_t  w_mem_a;
    byte_t  w_mem_dout;
    logic   w_mem_wr_go;
    logic   w_dc_done_go;
    logic   w_ic_done_go;
    logic   w_dc_done;
    logic   w_ic_done;

    assign w_rd_more = (r_cnt < r_len);
    assign w_wr_last = (({1'b0, r_cnt} + 4'd1) >= {1'b0, r_len});
    assign w_stall   = bus.io_buffer_full && is_io(r_pc);
    assign w_addr    = r_pc + {{(ADDR_W-CNT_W){1'b0}}, r_cnt};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and bus drive before the rdy freeze is applied.
    always_comb begin
        w_state_go   = r_state;
        w_mem_a      = 32'h0000_0000;
        w_mem_dout   = 8'h00;
        w_mem_wr_go  = 1'b0;
        w_dc_done_go = 1'b0;
        w_ic_done_go = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.iDC_en) begin
                    w_state_go = bus.iDC_ls ? WRITE : READ;
                end else if (bus.iIC_en) begin
                    w_state_go = READ;
                end else begin
                    w_state_go = IDLE;
                end
            end
            READ: begin
                if (w_rd_more) begin
                    w_mem_a    = w_addr;
                    w_state_go = READ;
                end else begin
                    w_state_go = DONE;
                end
            end
            WRITE: begin
                w_mem_a    = w_addr;
                w_mem_dout = get_byte(r_dt, r_cnt);
                if (w_stall) begin
                    w_state_go = WRITE;
                end else begin
                    w_mem_wr_go = 1'b1;
                    w_state_go  = w_wr_last ? DONE : WRITE;
                end
            end
            DONE: begin
                w_state_go   = IDLE;
                w_dc_done_go = (r_owner == OWN_DC);
                w_ic_done_go = (r_owner == OWN_IC);
            end
            default: begin
                w_state_go = IDLE;
            end
        endcase
    end

    assign w_state_nxt = rdy ? w_state_go : r_state;
    assign w_dc_done   = rdy && w_dc_done_go;
    assign w_ic_done   = rdy && w_ic_done_go;

    // Request latch, byte counter and little-endian read assembly.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_owner <= OWN_DC;
            r_pc    <= 32'h0000_0000;
            r_dt    <= 32'h0000_0000;
            r_len   <= 3'd0;
            r_cnt   <= 3'd0;
            r_data  <= 32'h0000_0000;
        end else if (rdy) begin
            case (r_state)
                IDLE: begin
                    r_cnt <= 3'd0;
                    if (bus.iDC_en) begin
                        r_owner <= OWN_DC;
                        r_pc    <= bus.iDC_pc;
                        r_dt    <= bus.iDC_dt;
                        r_len   <= bus.iDC_len;
                        r_data  <= 32'h0000_0000;
                    end else if (bus.iIC_en) begin
                        r_owner <= OWN_IC;
                        r_pc    <= bus.iIC_pc;
                        r_dt    <= 32'h0000_0000;
                        r_len   <= 3'd4;
                        r_data  <= 32'h0000_0000;
                    end else begin
                        r_owner <= r_owner;
                    end
                end
                READ: begin
                    // RAM returns the byte addressed one cycle earlier.
                    if (r_cnt != 3'd0) begin
                        r_data <= put_byte(r_data, r_cnt - 3'd1, bus.mem_din);
                    end else begin
                        r_data <= r_data;
                    end
                    if (w_rd_more) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                WRITE: begin
                    if (!w_stall) begin
                        r_cnt <= r_cnt + 3'd1;
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                DONE: begin
                    r_cnt <= 3'd0;
                end
                default: begin
                    r_cnt <= 3'd0;
                end
            endcase
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign bus.mem_a    = w_mem_a;
    assign bus.mem_dout = w_mem_dout;
    assign bus.mem_wr   = rdy && w_mem_wr_go;
    assign bus.oDC_done = w_dc_done;
    assign bus.oIC_done = w_ic_done;
    assign bus.oDC_dt   = w_dc_done ? r_data : 32'h0000_0000;
    assign bus.oIC_inst = w_ic_done ? r_data : 32'h0000_0000;

endmodule

// File: tb/tb_memctrl.sv
// Scoreboard bench for memctrl: a byte RAM model answers the bus, monitors log writes and
// done pulses with their cycle numbers, and each scenario task compares them to expectations.
module tb_memctrl;

    typedef struct {
        int          cyc;
        logic [31:0] a;
        logic [7:0]  d;
    } wr_t;

    typedef struct {
        int          cyc;
        bit          dc;
        logic [31:0] data;
    } done_t;

    logic clk = 1'b0;
    logic rst;
    logic rdy;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic [7:0] ram [0:4095];
    wr_t   wr_q[$];
    wr_t   expw_q[$];
    done_t done_q[$];
    done_t exp_q[$];

    memctrl_if bus();

    memctrl dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read byte RAM sharing the global enable; reset loads the fixed image.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 8'h00;
            ram[12'h100] <= 8'h11;
            ram[12'h101] <= 8'h22;
            ram[12'h102] <= 8'h33;
            ram[12'h103] <= 8'h44;
            ram[12'h202] <= 8'h77;
            bus.mem_din  <= 8'h00;
        end else if (rdy) begin
            if (bus.mem_wr) ram[bus.mem_a[11:0]] <= bus.mem_dout;
            bus.mem_din <= ram[bus.mem_a[11:0]];
        end
    end

    always @(negedge clk) begin
        wr_t   w;
        done_t d;
        if (bus.mem_wr === 1'b1) begin
            w.cyc = cyc; w.a = bus.mem_a; w.d = bus.mem_dout;
            wr_q.push_back(w);
        end
        if (bus.oDC_done === 1'b1) begin
            d.cyc = cyc; d.dc = 1'b1; d.data = bus.oDC_dt;
            done_q.push_back(d);
        end
        if (bus.oIC_done === 1'b1) begin
            d.cyc = cyc; d.dc = 1'b0; d.data = bus.oIC_inst;
            done_q.push_back(d);
        end
    end

    function automatic done_t mk_done(input int c, input bit dc, input logic [31:0] data);
        done_t d;
        d.cyc = c; d.dc = dc; d.data = data;
        return d;
    endfunction

    function automatic wr_t mk_wr(input int c, input logic [31:0] a, input logic [7:0] d);
        wr_t w;
        w.cyc = c; w.a = a; w.d = d;
        return w;
    endfunction

    task automatic clear_queues();
        wr_q.delete(); expw_q.delete(); done_q.delete(); exp_q.delete();
    endtask

    // Raises the requests after an edge; returns with acc = cycle number of cycle 0.
    task automatic issue(input bit dc_en, input bit ic_en, input bit ls, input logic [31:0] pc,
                         input logic [31:0] dt, input logic [2:0] len, input logic [31:0] ic_pc,
                         output int acc);
        @(posedge clk); #1;
        bus.iDC_en = dc_en; bus.iDC_ls = ls; bus.iDC_pc = pc; bus.iDC_dt = dt; bus.iDC_len = len;
        bus.iIC_en = ic_en; bus.iIC_pc = ic_pc;
        @(posedge clk); #1;
        acc = cyc;
    endtask

    task automatic wait_done(input int want, input int budget, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done_q.size() >= want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1;
        bus.iDC_en = 1'b0; bus.iDC_ls = 1'b0; bus.iDC_pc = 32'h0; bus.iDC_dt = 32'h0;
        bus.iDC_len = 3'd0; bus.iIC_en = 1'b0; bus.iIC_pc = 32'h0; bus.io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests++; if (bus.oDC_done !== 1'b0) begin fails++; $display("FAIL reset_oDC_done got %b want 0", bus.oDC_done); end
        tests++; if (bus.oIC_done !== 1'b0) begin fails++; $display("FAIL reset_oIC_done got %b want 0", bus.oIC_done); end
        tests++; if (bus.oDC_dt !== 32'h0) begin fails++; $display("FAIL reset_oDC_dt got %h want 0", bus.oDC_dt); end
        tests++; if (bus.oIC_inst !== 32'h0) begin fails++; $display("FAIL reset_oIC_inst got %h want 0", bus.oIC_inst); end
        tests++; if (bus.mem_wr !== 1'b0) begin fails++; $display("FAIL reset_mem_wr got %b want 0", bus.mem_wr); end
        tests++; if (bus.mem_a !== 32'h0) begin fails++; $display("FAIL reset_mem_a got %h want 0", bus.mem_a); end
        tests++; if (bus.mem_dout !== 8'h0) begin fails++; $display("FAIL reset_mem_dout got %h want 0", bus.mem_dout); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_load();
        int acc; bit ok; done_t g; done_t e;
        clear_queues();
        issue(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 3'd4, 32'h0, acc);
        exp_q.push_back(mk_done(acc + 5, 1'b1, 32'h44332211));
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if (bus.mem_a !== (32'h100 + k) || bus.mem_wr !== 1'b0) begin
                fails++; $display("FAIL load_addr c%0d got a=%h wr=%b want a=%h wr=0", k, bus.mem_a, bus.mem_wr, 32'h100 + k);
            end
        end
        wait_done(1, 20, ok);
        @(posedge clk); #1; bus.iDC_en = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL load_timeout got no done want done"); end
        if (ok) begin
            g = done_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (g.cyc !== e.cyc || g.dc !== e.dc || g.data !== e.data) begin
                fails++; $display("FAIL load_done got cyc=%0d dc=%b dt=%h want cyc=%0d dc=%b dt=%h", g.cyc, g.dc, g.data, e.cyc, e.dc, e.data);
            end
        end
        repeat (3) @(negedge clk);
        tests++; if (done_q.size() != 0) begin fails++; $display("FAIL load_extra_done got %0d want 0", done_q.size()); end
    endtask

    task automatic test_store();
        int acc; bit ok; done_t g; done_t e; wr_t gw; wr_t ew;
        clear_queues();
        issue(1'b1, 1'b0, 1'b1, 32'h200, 32'hAABBCCDD, 3'd2, 32'h0, acc);
        expw_q.push_back(mk_wr(acc, 32'h200, 8'hDD));
        expw_q.push_back(mk_wr(acc + 1, 32'h201, 8'hCC));
        exp_q.push_back(mk_done(acc + 2, 1'b1, 32'h0));
        wait_done(1, 20, ok);
        @(posedge clk); #1; bus.iDC_en = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL store_timeout got no done want done"); end
        if (ok) begin
            g = done_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (g.cyc !== e.cyc || g.dc !== e.dc) begin
                fails++; $display("FAIL store_done got cyc=%0d dc=%b want cyc=%0d dc=%b", g.cyc, g.dc, e.cyc, e.dc);
            end
        end
        tests++; if (wr_q.size() != 2) begin fails++; $display("FAIL store_nwrites got %0d want 2", wr_q.size()); end
        while (wr_q.size() > 0 && expw_q.size() > 0) begin
            gw = wr_q.pop_front(); ew = expw_q.pop_front();
            tests++;
            if (gw.cyc !== ew.cyc || gw.a !== ew.a || gw.d !== ew.d) begin
                fails++; $display("FAIL store_write got c=%0d a=%h d=%h want c=%0d a=%h d=%h", gw.cyc, gw.a, gw.d, ew.cyc, ew.a, ew.d);
            end
        end
        tests++; if (ram[12'h200] !== 8'hDD) begin fails++; $display("FAIL store_ram200 got %h want dd", ram[12'h200]); end
        tests++; if (ram[12'h202] !== 8'h77) begin fails++; $display("FAIL store_ram202 got %h want 77", ram[12'h202]); end
    endtask

    task automatic test_priority();
        int acc; bit ok1; bit ok2; done_t g; done_t e;
        clear_queues();
        issue(1'b1, 1'b1, 1'b0, 32'h100, 32'h0, 3'd1, 32'h100, acc);
        exp_q.push_back(mk_done(acc + 2, 1'b1, 32'h00000011));
        exp_q.push_back(mk_done(acc + 9, 1'b0, 32'h44332211));
        wait_done(1, 20, ok1);
        @(posedge clk); #1; bus.iDC_en = 1'b0;
        wait_done(2, 20, ok2);
        @(posedge clk); #1; bus.iIC_en = 1'b0;
        tests++; if (!ok1 || !ok2) begin fails++; $display("FAIL prio_timeout got %0d dones want 2", done_q.size()); end
        while (done_q.size() > 0 && exp_q.size() > 0) begin
            g = done_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (g.cyc !== e.cyc || g.dc !== e.dc || g.data !== e.data) begin
                fails++; $display("FAIL prio_done got cyc=%0d dc=%b dt=%h want cyc=%0d dc=%b dt=%h", g.cyc, g.dc, g.data, e.cyc, e.dc, e.data);
            end
        end
    endtask

    task automatic test_io_stall();
        int acc; bit ok; done_t g; wr_t gw;
        clear_queues();
        bus.io_buffer_full = 1'b1;
        issue(1'b1, 1'b0, 1'b1, 32'h30000, 32'h0000005A, 3'd1, 32'h0, acc);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            tests++;
            if (bus.mem_wr !== 1'b0) begin fails++; $display("FAIL io_stall_wr c%0d got %b want 0", k, bus.mem_wr); end
        end
        @(posedge clk); #1; bus.io_buffer_full = 1'b0;
        wait_done(1, 20, ok);
        @(posedge clk); #1; bus.iDC_en = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL io_timeout got no done want done"); end
        if (ok) begin
            g = done_q.pop_front();
            tests++; if (g.cyc !== acc + 4) begin fails++; $display("FAIL io_done_cyc got %0d want %0d", g.cyc, acc + 4); end
        end
        tests++;
        if (wr_q.size() != 1) begin
            fails++; $display("FAIL io_nwrites got %0d want 1", wr_q.size());
        end else begin
            gw = wr_q.pop_front();
            if (gw.cyc !== acc + 3 || gw.a !== 32'h30000 || gw.d !== 8'h5A) begin
                fails++; $display("FAIL io_write got c=%0d a=%h d=%h want c=%0d a=30000 d=5a", gw.cyc, gw.a, gw.d, acc + 3);
            end
        end
        // A full IO buffer must not stall a RAM-space store.
        clear_queues();
        bus.io_buffer_full = 1'b1;
        issue(1'b1, 1'b0, 1'b1, 32'h400, 32'h04030201, 3'd4, 32'h0, acc);
        wait_done(1, 20, ok);
        @(posedge clk); #1; bus.iDC_en = 1'b0; bus.io_buffer_full = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL ram_store_timeout got no done want done"); end
        if (ok) begin
            g = done_q.pop_front();
            tests++; if (g.cyc !== acc + 4) begin fails++; $display("FAIL ram_store_cyc got %0d want %0d", g.cyc, acc + 4); end
        end
        tests++; if (wr_q.size() != 4) begin fails++; $display("FAIL ram_store_nwrites got %0d want 4", wr_q.size()); end
        tests++;
        if ({ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]} !== 32'h04030201) begin
            fails++; $display("FAIL ram_store_data got %h%h%h%h want 04030201", ram[12'h403], ram[12'h402], ram[12'h401], ram[12'h400]);
        end
    endtask

    task automatic test_rdy();
        int acc; bit ok; done_t g; done_t e;
        clear_queues();
        issue(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 3'd4, 32'h0, acc);
        exp_q.push_back(mk_done(acc + 7, 1'b1, 32'h44332211));
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rdy = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            tests++;
            if (bus.mem_a !== 32'h102 || bus.mem_wr !== 1'b0 || bus.oDC_done !== 1'b0) begin
                fails++; $display("FAIL rdy_freeze f%0d got a=%h wr=%b done=%b want a=102 wr=0 done=0", k, bus.mem_a, bus.mem_wr, bus.oDC_done);
            end
        end
        @(posedge clk); #1; rdy = 1'b1;
        wait_done(1, 20, ok);
        @(posedge clk); #1; bus.iDC_en = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL rdy_timeout got no done want done"); end
        if (ok) begin
            g = done_q.pop_front(); e = exp_q.pop_front();
            tests++;
            if (g.cyc !== e.cyc || g.data !== e.data) begin
                fails++; $display("FAIL rdy_done got cyc=%0d dt=%h want cyc=%0d dt=%h", g.cyc, g.data, e.cyc, e.data);
            end
        end
    endtask

    task automatic test_rst_mid();
        int acc; bit ok; done_t g;
        clear_queues();
        issue(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 3'd4, 32'h0, acc);
        repeat (2) @(negedge clk);
        @(posedge clk); #1; rst = 1'b1; bus.iDC_en = 1'b0;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        tests++; if (bus.mem_a !== 32'h0) begin fails++; $display("FAIL rst_mid_idle got a=%h want 0", bus.mem_a); end
        repeat (8) @(negedge clk);
        tests++; if (done_q.size() != 0) begin fails++; $display("FAIL rst_mid_nodone got %0d want 0", done_q.size()); end
        clear_queues();
        issue(1'b1, 1'b0, 1'b0, 32'h102, 32'h0, 3'd2, 32'h0, acc);
        wait_done(1, 20, ok);
        @(posedge clk); #1; bus.iDC_en = 1'b0;
        tests++; if (!ok) begin fails++; $display("FAIL rst_mid_timeout got no done want done"); end
        if (ok) begin
            g = done_q.pop_front();
            tests++;
            if (g.cyc !== acc + 3 || g.data !== 32'h00004433) begin
                fails++; $display("FAIL rst_mid_after got cyc=%0d dt=%h want cyc=%0d dt=00004433", g.cyc, g.data, acc + 3);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_store();
        test_priority();
        test_io_stall();
        test_rdy();
        test_rst_mid();
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
